rr_arbiter_n: RTL and testbench

//  N-way round-robin arbiter with grant hold, starvation limiter and lock.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 40 ++++
 rtl/rr_arbiter_n.sv | 111 +++++++++++
 tb/tb_rr_arbiter_n.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers.
// Used by the round-robin picker and the arbiter top.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int ARB_N_DEF        = 4;
   localparam int ARB_MAX_HOLD_DEF = 8;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
// Scans from start upward, wrapping past N-1 to 0.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N = ARB_N_DEF,
   localparam int IDW = clog2_min1(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] start,
   output logic [N-1:0]   win,
   output logic [IDW-1:0] idx,
   output logic           any
);

   int           pos;
   logic         found;
   logic [N-1:0] shifted;

   always_comb begin
      win     = '0;
      idx     = '0;
      found   = 1'b0;
      pos     = 0;
      shifted = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start) + k;
         if (pos >= N) pos = pos - N;
         shifted = req >> pos;
         if (!found && shifted[0]) begin
            found = 1'b1;
            win   = N'(1) << pos;
            idx   = IDW'(pos);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with grant hold,
// hold-limit preemption and owner lock.
module rr_arbiter_n
   import arb_pkg::*;
#(
   parameter int N        = ARB_N_DEF,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
   localparam int IDW     = clog2_min1(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic           lock,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           preempt
);

   localparam int             HCW      = clog2_min1(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
   localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

   arb_state_e     state, state_n;
   logic [N-1:0]   gnt_q, gnt_n;
   logic [IDW-1:0] id_q, id_n;
   logic [IDW-1:0] last_q, last_n;
   logic [HCW-1:0] hold_q, hold_n;
   logic           pre_q, pre_n;

   logic [N-1:0]   cand, win;
   logic [IDW-1:0] start, win_idx;
   logic           win_any;
   logic           own_req, others, hold_hit, take;

   // Owner is masked out so a preempt always moves the grant on
   assign cand     = req & ~gnt_q;
   assign own_req  = |(req & gnt_q);
   assign others   = |cand;
   assign start    = (last_q == LAST_RST) ? '0 : last_q + 1'b1;
   assign hold_hit = (MAX_HOLD != 0) && (hold_q >= HOLD_MAX);

   rr_pick #(.N(N)) u_pick (
      .req   (cand),
      .start (start),
      .win   (win),
      .idx   (win_idx),
      .any   (win_any)
   );

   always_comb begin
      state_n = state;
      gnt_n   = gnt_q;
      id_n    = id_q;
      last_n  = last_q;
      hold_n  = hold_q;
      pre_n   = 1'b0;
      take    = 1'b0;
      unique case (state)
         IDLE: take = win_any;
         GRANT: begin
            if (!own_req) begin
               take = win_any;
               if (!win_any) begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  id_n    = '0;
                  hold_n  = '0;
               end
            end else if (others && !lock && hold_hit) begin
               take  = 1'b1;
               pre_n = 1'b1;
            end else if (others && hold_q < HOLD_MAX) begin
               hold_n = hold_q + 1'b1;
            end
         end
         default: ;
      endcase
      if (take) begin
         state_n = GRANT;
         gnt_n   = win;
         id_n    = win_idx;
         last_n  = win_idx;
         hold_n  = HCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt_q  <= '0;
         id_q   <= '0;
         last_q <= LAST_RST;
         hold_q <= '0;
         pre_q  <= 1'b0;
      end else begin
         state  <= state_n;
         gnt_q  <= gnt_n;
         id_q   <= id_n;
         last_q <= last_n;
         hold_q <= hold_n;
         pre_q  <= pre_n;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = id_q;
   assign gnt_valid = |gnt_q;
   assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: directed N=4 vectors,
// N=5 invariant/starvation run and N=1 delay check.
module tb_rr_arbiter_n;

   logic       clk;
   logic       rst_n, rst_b;
   logic [3:0] req4, gnt4;
   logic       lock4, v4, p4;
   logic [1:0] id4;
   logic [4:0] req5, gnt5;
   logic       lock5, v5, p5;
   logic [2:0] id5;
   logic [0:0] req1, gnt1, id1;
   logic       lock1, v1, p1;

   int n_tests = 0;
   int n_fail  = 0;
   bit d5_done = 0;
   bit d1_done = 0;

   typedef struct {
      logic [3:0] gnt;
      logic       pre;
      bit         rs;
      string      nm;
   } exp_t;

   exp_t q4[$];
   exp_t e4;
   bit   q1[$];
   bit   b1;
   int   wait_cnt[5];

   rr_arbiter_n #(.N(4), .MAX_HOLD(4)) d4 (
      .clk(clk), .rst_n(rst_n), .req(req4), .lock(lock4),
      .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4), .preempt(p4)
   );

   rr_arbiter_n #(.N(5), .MAX_HOLD(4)) d5 (
      .clk(clk), .rst_n(rst_b), .req(req5), .lock(lock5),
      .gnt(gnt5), .gnt_id(id5), .gnt_valid(v5), .preempt(p5)
   );

   rr_arbiter_n #(.N(1), .MAX_HOLD(4)) d1 (
      .clk(clk), .rst_n(rst_b), .req(req1), .lock(lock1),
      .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1), .preempt(p1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh_idx(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic cyc(input bit rs, input logic [3:0] r, input bit l,
                      input logic [3:0] eg, input bit ep,
                      input string nm);
      exp_t e;
      @(negedge clk);
      rst_n = rs;
      req4  = r;
      lock4 = l;
      e.gnt = eg;
      e.pre = ep;
      e.rs  = rs;
      e.nm  = nm;
      q4.push_back(e);
   endtask

   // Monitor for the N=4 scoreboard
   always @(posedge clk) begin
      #1;
      if (q4.size() > 0) begin
         e4 = q4.pop_front();
         check({e4.nm, "_gnt"}, 32'(gnt4), 32'(e4.gnt));
         check({e4.nm, "_valid"}, 32'(v4), 32'(|e4.gnt));
         check({e4.nm, "_pre"}, 32'(p4), 32'(e4.pre));
         if (e4.gnt != 4'b0 || !e4.rs)
            check({e4.nm, "_id"}, 32'(id4), 32'(oh_idx(e4.gnt)));
      end
   end

   // Monitor for N=1: grant is request delayed by one edge
   always @(posedge clk) begin
      #1;
      if (q1.size() > 0) begin
         b1 = q1.pop_front();
         check("n1_gnt", 32'(gnt1), 32'(b1));
         check("n1_id", 32'(id1), 32'd0);
         check("n1_pre", 32'(p1), 32'd0);
      end
   end

   // Monitor for N=5: invariants and starvation bound
   always @(posedge clk) begin
      #1;
      if (rst_b && !d5_done) begin
         check("n5_onehot", 32'(gnt5 & (gnt5 - 5'd1)), 32'd0);
         check("n5_id_range", 32'(id5 <= 3'd4), 32'd1);
         check("n5_valid", 32'(v5), 32'(|gnt5));
         check("n5_gnt_at_id", 32'((gnt5 >> id5) & 5'd1), 32'(v5));
         check("n5_pre_has_gnt", 32'(p5 & ~v5), 32'd0);
         for (int i = 0; i < 5; i++) begin
            if (((req5 >> i) & ~(gnt5 >> i) & 5'd1) != 5'd0)
               wait_cnt[i]++;
            else
               wait_cnt[i] = 0;
         end
         for (int i = 0; i < 5; i++)
            if (wait_cnt[i] > (5 - 1) * 4 + 5)
               check("n5_starve", 32'(wait_cnt[i]), 32'd21);
      end
   end

   initial begin
      rst_b = 1'b0;
      req5  = '0;
      lock5 = 1'b0;
      req1  = '0;
      lock1 = 1'b0;
      for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
   end

   initial begin
      wait (rst_b);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         req5 = req5 ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
      end
      @(negedge clk);
      d5_done = 1;
   end

   initial begin
      logic [31:0] pat;
      pat = 32'hB3C5_19E7;
      wait (rst_b);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         req1 = 1'(pat >> (k % 32));
         q1.push_back(req1[0]);
      end
      @(negedge clk);
      req1 = '0;
      repeat (2) @(negedge clk);
      d1_done = 1;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: timeout at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      req4  = '0;
      lock4 = 1'b0;

      cyc(0, 4'b0001, 0, 4'b0000, 0, "rst_a");
      cyc(0, 4'b0001, 0, 4'b0000, 0, "rst_b");
      cyc(1, 4'b0001, 0, 4'b0001, 0, "t1_first");
      cyc(1, 4'b0001, 0, 4'b0001, 0, "t1_hold");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_gnt", 32'(gnt4), 32'd0);
      check("t1_async_valid", 32'(v4), 32'd0);

      cyc(0, 4'b1111, 0, 4'b0000, 0, "t2_rst");
      for (int k = 0; k < 5; k++)
         for (int c = 0; c < 4; c++)
            cyc(1, 4'b1111, 0, 4'(1 << (k % 4)),
                (c == 0 && k > 0), "t2_rr");

      cyc(0, 4'b0000, 0, 4'b0000, 0, "t3_rst");
      cyc(1, 4'b0100, 0, 4'b0100, 0, "t3_own2");
      cyc(1, 4'b0110, 0, 4'b0100, 0, "t3_wait");
      cyc(1, 4'b1010, 0, 4'b1000, 0, "t3_handoff");
      cyc(1, 4'b1010, 0, 4'b1000, 0, "t3_keep");

      cyc(1, 4'b0010, 0, 4'b0010, 0, "t4_own1");
      repeat (12) cyc(1, 4'b0011, 1, 4'b0010, 0, "t4_lock");
      cyc(1, 4'b0011, 0, 4'b0001, 1, "t4_preempt");
      cyc(1, 4'b0011, 0, 4'b0001, 0, "t4_after");

      cyc(0, 4'b0000, 0, 4'b0000, 0, "t5_rst");
      cyc(1, 4'b0101, 0, 4'b0001, 0, "t5_wrap");
      cyc(1, 4'b0100, 0, 4'b0100, 0, "t5_next");

      repeat (3) cyc(1, 4'b0101, 0, 4'b0100, 0, "t7_hold");
      cyc(1, 4'b0001, 0, 4'b0001, 0, "t7_rel");
      cyc(1, 4'b0000, 0, 4'b0000, 0, "t7_idle");

      cyc(1, 4'b0100, 0, 4'b0100, 0, "t8_own2");
      cyc(1, 4'b1000, 1, 4'b1000, 0, "t8_lock_rel");

      @(negedge clk);
      req4  = '0;
      lock4 = 1'b0;
      wait (d5_done && d1_done);
      repeat (2) @(negedge clk);
      check("q4_drained", 32'(q4.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
